// File: rtl/dco_pkg.sv
// Shared definitions for the DCO frequency meter.
// Holds the measurement FSM state type, gate-window sizing constants and the
// helper that turns a gate select code into a window length in clk cycles.
package dco_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StDone
  } dco_state_e;

  // Shortest gate window is 2^GATE_BASE_LOG2 cycles.
  localparam int unsigned GATE_BASE_LOG2 = 6;
  localparam int unsigned GATE_SEL_W     = 3;
  // Wide enough to hold the longest window, 2^(GATE_BASE_LOG2 + 2^GATE_SEL_W - 1).
  localparam int unsigned GATE_CNT_W     = GATE_BASE_LOG2 + (1 << GATE_SEL_W);

  // Window length N = 2^(sel + GATE_BASE_LOG2).
  function automatic logic [GATE_CNT_W-1:0] gate_len(input logic [GATE_SEL_W-1:0] sel);
    logic [GATE_CNT_W-1:0] one;
    one = GATE_CNT_W'(1);
    return one << (int'(sel) + GATE_BASE_LOG2);
  endfunction

endpackage

// File: rtl/dco_edge_sync.sv
// Synchronizer plus rising-edge detector for an asynchronous DCO tap.
// The whole chain freezes while ena is low so that a paused measurement sees
// a continuous sample stream once it resumes.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset, clears every flop
//   ena      advance the chain when high, hold when low
//   din      asynchronous input
//   edge_det one-cycle pulse per synchronized rising edge
//
// SYNC_STAGES must be at least 2.
module dco_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else if (ena) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/dco_freq_meter.sv
// DCO frequency meter: counts synchronized rising edges of dco_in over a gate
// window of N = 2^(gate_sel+6) clk cycles, in single-shot or continuous mode.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset; aborts any window in flight
//   ena         global enable; low freezes FSM, counters and synchronizer
//   dco_in      DCO output under measurement (asynchronous)
//   gate_sel    window length select, sampled at window start only
//   start       single-shot request, level-sampled in idle
//   cont        continuous mode, sampled in idle and at window end
//   count_out   edge count of the last completed window (saturating)
//   count_valid one-cycle pulse when count_out updates
//   busy        high while measuring and during the window-end cycle
//   overflow    sticky saturation flag, cleared at the next window start
module dco_freq_meter
  import dco_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  dco_in,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  input  logic                  start,
  input  logic                  cont,
  output logic [CNT_W-1:0]      count_out,
  output logic                  count_valid,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  dco_state_e            state_q, state_d;
  logic [GATE_CNT_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]      count_out_q, count_out_d;
  logic                  count_valid_q, count_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  edge_det;
  logic                  win_start;

  dco_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .din      (dco_in),
    .edge_det (edge_det)
  );

  always_comb begin
    state_d       = state_q;
    gate_cnt_d    = gate_cnt_q;
    edge_cnt_d    = edge_cnt_q;
    count_out_d   = count_out_q;
    overflow_d    = overflow_q;
    count_valid_d = 1'b0;
    win_start     = 1'b0;

    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (start || cont) begin
            state_d   = StMeasure;
            win_start = 1'b1;
          end
        end
        StMeasure: begin
          gate_cnt_d = gate_cnt_q - 1'b1;
          if (edge_det) begin
            if (edge_cnt_q == CntMax) begin
              overflow_d = 1'b1;
            end else begin
              edge_cnt_d = edge_cnt_q + 1'b1;
            end
          end
          if (gate_cnt_q == GATE_CNT_W'(1)) begin
            state_d       = StDone;
            // Capture the updated count so an edge in the last cycle is kept.
            count_out_d   = edge_cnt_d;
            count_valid_d = 1'b1;
          end
        end
        StDone: begin
          if (cont) begin
            state_d   = StMeasure;
            win_start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (win_start) begin
        gate_cnt_d = gate_len(gate_sel);
        edge_cnt_d = '0;
        overflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      gate_cnt_q    <= '0;
      edge_cnt_q    <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gate_cnt_q    <= gate_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign busy        = (state_q != StIdle);
  assign overflow    = overflow_q;

endmodule
